// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: start, LSB-first data, optional parity, stop bits.
// Parity stage is built only when UART_TX_PARITY_EN is defined.
module uart_tx_serializer #(
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 baud_tick,
  input  logic                 tx_start,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 baud_en,
  output logic                 tx,
  output logic                 busy,
  output logic                 done
);

  localparam int CW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] DLAST = CW'(DATA_BITS - 1);
  localparam logic [CW-1:0] SLAST = CW'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
`ifdef UART_TX_PARITY_EN
    PARITY = 3'd4,
`endif
    STOP  = 3'd3
  } state_t;

  state_t               state_q, state_d;
  logic [DATA_BITS-1:0] sh_q, sh_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 tx_q, tx_d;
  logic                 busy_q, busy_d;
  logic                 en_q, en_d;
  logic                 done_q, done_d;

`ifdef UART_TX_PARITY_EN
  logic par_q, par_d;

  always_ff @(posedge clk) begin
    if (!rst) par_q <= 1'b0;
    else      par_q <= par_d;
  end
`else
  logic unused_par;
  assign unused_par = (PARITY_ODD != 0);
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      sh_q    <= '0;
      cnt_q   <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      en_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      en_q    <= en_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    en_d    = en_q;
    done_d  = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (tx_start) begin
          state_d = START;
          sh_d    = tx_data;
          cnt_d   = '0;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
          en_d    = 1'b1;
`ifdef UART_TX_PARITY_EN
          par_d   = (^tx_data) ^ (PARITY_ODD != 0);
`endif
        end
      end
      START: begin
        if (baud_tick) begin
          state_d = DATA;
          tx_d    = sh_q[0];
          sh_d    = sh_q >> 1;
        end
      end
      DATA: begin
        if (baud_tick) begin
          if (cnt_q == DLAST) begin
            cnt_d = '0;
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
            tx_d    = par_q;
`else
            state_d = STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            cnt_d = cnt_q + CW'(1);
            tx_d  = sh_q[0];
            sh_d  = sh_q >> 1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (baud_tick) begin
          state_d = STOP;
          tx_d    = 1'b1;
        end
      end
`endif
      STOP: begin
        tx_d = 1'b1;
        if (baud_tick) begin
          if (cnt_q == SLAST) begin
            state_d = IDLE;
            cnt_d   = '0;
            busy_d  = 1'b0;
            en_d    = 1'b0;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign tx      = tx_q;
  assign busy    = busy_q;
  assign baud_en = en_q;
  assign done    = done_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer: 8N1/even and 7-bit/2-stop/odd instances,
// each fed by a 4-cycle baud generator model.
module tb_uart_tx_serializer;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick_force;
  logic       start;
  logic       sel;
  logic [8:0] data;

  logic en0, tx0, busy0, done0;
  logic en1, tx1, busy1, done1;
  logic [1:0] gc0, gc1;
  logic tick0, tick1, st0, st1;
  logic otx, obusy, oen, odone;

  int nvec = 0;
  int nerr = 0;
  bit exp_q[$];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (en0) gc0 <= gc0 + 2'd1;
    else     gc0 <= 2'd0;
    if (en1) gc1 <= gc1 + 2'd1;
    else     gc1 <= 2'd0;
  end

  assign tick0 = tick_force | (en0 && gc0 == 2'd3);
  assign tick1 = tick_force | (en1 && gc1 == 2'd3);
  assign st0   = start & ~sel;
  assign st1   = start & sel;
  assign otx   = sel ? tx1 : tx0;
  assign obusy = sel ? busy1 : busy0;
  assign oen   = sel ? en1 : en0;
  assign odone = sel ? done1 : done0;

  uart_tx_serializer #(
    .DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(0)
  ) u0 (
    .clk(clk), .rst(rst), .baud_tick(tick0),
    .tx_start(st0), .tx_data(data[7:0]),
    .baud_en(en0), .tx(tx0), .busy(busy0), .done(done0)
  );

  uart_tx_serializer #(
    .DATA_BITS(7), .STOP_BITS(2), .PARITY_ODD(1)
  ) u1 (
    .clk(clk), .rst(rst), .baud_tick(tick1),
    .tx_start(st1), .tx_data(data[6:0]),
    .baud_en(en1), .tx(tx1), .busy(busy1), .done(done1)
  );

  // Expected line levels, one entry per bit period.
  function automatic void build(input bit s, input logic [8:0] d);
    int db, sb;
    bit p;
    db = s ? 7 : 8;
    sb = s ? 2 : 1;
    p  = s;
    exp_q.delete();
    exp_q.push_back(1'b0);
    for (int i = 0; i < db; i++) begin
      exp_q.push_back(d[i]);
      p = p ^ d[i];
    end
`ifdef UART_TX_PARITY_EN
    exp_q.push_back(p);
`endif
    for (int i = 0; i < sb; i++) exp_q.push_back(1'b1);
  endfunction

  task automatic run_frame(input bit s, input logic [8:0] d,
                           input bit started, input int poke_at,
                           input logic [8:0] poke_d, input int abort_at,
                           input bit chain, input logic [8:0] chain_d);
    int n;
    logic [3:0] got, want;
    build(s, d);
    n = exp_q.size() * 4;
    if (!started) begin
      @(negedge clk);
      sel   = s;
      data  = d;
      start = 1'b1;
    end
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      got  = {otx, obusy, oen, odone};
      want = {exp_q[c / 4], 3'b110};
      nvec++;
      if (got !== want) begin
        nerr++;
        $display("FAIL frame d=%h s=%0d cyc=%0d got=%b want=%b",
                 d, s, c, got, want);
      end
      start = (c == poke_at);
      data  = (c == poke_at) ? poke_d : 9'($urandom);
      if (c == abort_at) begin
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        start = 1'b0;
        got = {otx, obusy, oen, odone};
        nvec++;
        if (got !== 4'b1000) begin
          nerr++;
          $display("FAIL abort d=%h got=%b want=1000", d, got);
        end
        repeat (2) begin
          @(negedge clk);
          got = {otx, obusy, oen, odone};
          nvec++;
          if (got !== 4'b1000) begin
            nerr++;
            $display("FAIL post_abort got=%b want=1000", got);
          end
        end
        return;
      end
    end
    @(negedge clk);
    got = {otx, obusy, oen, odone};
    nvec++;
    if (got !== 4'b1001) begin
      nerr++;
      $display("FAIL done d=%h s=%0d got=%b want=1001", d, s, got);
    end
    start = chain;
    data  = chain ? chain_d : 9'($urandom);
    if (!chain) begin
      @(negedge clk);
      got = {otx, obusy, oen, odone};
      nvec++;
      if (got !== 4'b1000) begin
        nerr++;
        $display("FAIL idle_after d=%h got=%b want=1000", d, got);
      end
    end
  endtask

  task automatic test_reset();
    logic [7:0] got;
    rst = 1'b0;
    start = 1'b0;
    tick_force = 1'b0;
    sel = 1'b0;
    data = '0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      got = {tx0, busy0, en0, done0, tx1, busy1, en1, done1};
      nvec++;
      if (got !== 8'b1000_1000) begin
        nerr++;
        $display("FAIL reset_idle cyc=%0d got=%b want=10001000", i, got);
      end
      tick_force = ~tick_force;
    end
    tick_force = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_frame();
    run_frame(1'b0, 9'h0A5, 1'b0, -1, '0, -1, 1'b0, '0);
  endtask

  task automatic test_parity();
    run_frame(1'b0, 9'h007, 1'b0, -1, '0, -1, 1'b0, '0);
    run_frame(1'b1, 9'h007, 1'b0, -1, '0, -1, 1'b0, '0);
  endtask

  task automatic test_back_to_back();
    run_frame(1'b0, 9'h03C, 1'b0, 9, 9'h0FF, -1, 1'b1, 9'h081);
    run_frame(1'b0, 9'h081, 1'b1, -1, '0, -1, 1'b0, '0);
  endtask

  task automatic test_reset_mid_frame();
    run_frame(1'b0, 9'h000, 1'b0, -1, '0, 17, 1'b0, '0);
    run_frame(1'b0, 9'h055, 1'b0, -1, '0, -1, 1'b0, '0);
  endtask

  task automatic test_seven_two();
    run_frame(1'b1, 9'h041, 1'b0, -1, '0, -1, 1'b0, '0);
  endtask

  task automatic test_random();
    bit s, pend, ch;
    logic [8:0] d, nd;
    int poke;
    pend = 1'b0;
    s = 1'b0;
    d = 9'($urandom);
    for (int i = 0; i < 16; i++) begin
      if (!pend) s = 1'($urandom);
      nd   = 9'($urandom);
      ch   = (i < 15) && ($urandom_range(0, 2) == 0);
      poke = ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(0, 39));
      run_frame(s, d, pend, poke, 9'($urandom), -1, ch, nd);
      pend = ch;
      d = nd;
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_parity();
    test_back_to_back();
    test_reset_mid_frame();
    test_seven_two();
    test_random();
    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
